// File: rtl/row_scan_pkg.sv
// rtl/row_scan_pkg.sv - state enum and counter sizing shared by the row scan decoder
package row_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Wide enough to hold the largest terminal count without ever wrapping.
  function automatic int cnt_width(input int dwell, input int blank);
    int top;
    top = (dwell > blank) ? dwell : blank;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/row_scan_decoder_if.sv
// rtl/row_scan_decoder_if.sv - control inputs and row drive outputs of the row scan decoder
interface row_scan_decoder_if #(
  parameter int N = 3
) ();

  logic             ena;
  logic             mode;
  logic [N-1:0]     sel;
  logic [2**N-1:0]  out;
  logic [N-1:0]     row;
  logic             frame_start;

  modport master (
    output ena, mode, sel,
    input  out, row, frame_start
  );

  modport slave (
    input  ena, mode, sel,
    output out, row, frame_start
  );

endinterface

// File: rtl/row_scan_decoder_decoder_n_to_2n.sv
// rtl/row_scan_decoder_decoder_n_to_2n.sv - N-bit index plus enable to 2**N one-hot
module decoder_n_to_2n #(
  parameter int N = 3
) (
  input  logic [N-1:0]    i_idx,
  input  logic            i_en,
  output logic [2**N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/row_scan_decoder.sv
// rtl/row_scan_decoder.sv - scanned or directly selected one-hot row driver with blanking
module row_scan_decoder
  import row_scan_pkg::*;
#(
  parameter int N            = 3,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  row_scan_decoder_if.slave   bus
);

  localparam int W  = 2**N;
  localparam int CW = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [N-1:0]  r_row;
  logic [N-1:0]  w_row_nx;
  logic [W-1:0]  r_out;
  logic [W-1:0]  w_out_nx;
  logic          r_frame_start;
  logic          w_frame_start_nx;
  logic          w_drive_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_row         <= '0;
      r_out         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_row         <= w_row_nx;
      r_out         <= w_out_nx;
      r_frame_start <= w_frame_start_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_row_nx   = r_row;
    case (r_state)
      IDLE: begin
        if (bus.ena) begin
          w_state_nx = BLANK;
          w_cnt_nx   = '0;
        end
      end
      BLANK: begin
        // The blank always runs to completion; mode only decides which row follows.
        if (r_cnt == BLANK_LAST) begin
          w_state_nx = DRIVE;
          w_cnt_nx   = '0;
          if (bus.mode) begin
            w_row_nx = bus.sel;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      DRIVE: begin
        if (bus.mode) begin
          w_cnt_nx = '0;
          if (bus.sel != r_row) begin
            w_state_nx = BLANK;
          end
        end else if (r_cnt == DWELL_LAST) begin
          w_state_nx = BLANK;
          w_cnt_nx   = '0;
          w_row_nx   = r_row + N'(1);
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    // Dropping enable beats any pending dwell expiry, so the row never advances here.
    if (!bus.ena) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
      w_row_nx   = r_row;
    end
  end

  assign w_drive_nx       = (w_state_nx == DRIVE);
  assign w_frame_start_nx = w_drive_nx && (r_state != DRIVE) && (w_row_nx == '0);

  decoder_n_to_2n #(
    .N (N)
  ) u_decoder (
    .i_idx    (w_row_nx),
    .i_en     (w_drive_nx),
    .o_onehot (w_out_nx)
  );

  assign bus.out         = r_out;
  assign bus.row         = r_row;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_row_scan_decoder.sv
// tb/tb_row_scan_decoder.sv - randomized scenario bench for row_scan_decoder (N=2, dwell 3, blank 2)
module tb_row_scan_decoder;

  localparam int N     = 2;
  localparam int DWELL = 3;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [1:0] m_row = 2'd0;

  row_scan_decoder_if #(.N(N)) bus ();

  row_scan_decoder #(
    .N            (N),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Out must be dark or exactly the bit named by row, every cycle.
  always @(negedge clk) begin
    logic [3:0] hot;
    if (mon_en) begin
      hot = 4'b0001 << bus.row;
      n_cmp++;
      if (bus.out !== 4'b0000 && bus.out !== hot) begin
        n_bad++;
        $display("FAIL onehot_vs_row: out=%b row=%0d required 0000 or %b", bus.out, bus.row, hot);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.ena  = 1'b0;
    bus.mode = 1'($urandom);
    bus.sel  = 2'($urandom);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== 7'b0000_00_0) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: out=%b row=%0d fs=%b required 0000/0/0", i, bus.out, bus.row, bus.frame_start);
      end
    end
    m_row  = 2'd0;
    mon_en = 1'b1;
  endtask

  // Starts from IDLE; after the t-th edge the bench expects slot (t-1)/SLOT, with
  // the first BLANK edges of each slot dark and the rest driving the slot's row.
  task automatic test_auto_scan(input int cycles, input bit drop);
    logic [1:0] r0, e_row;
    logic [3:0] e_out, one;
    logic       e_fs;
    int         q, s;
    one      = 4'b0001;
    r0       = m_row;
    e_row    = r0;
    bus.mode = 1'b0;
    bus.ena  = 1'b1;
    for (int t = 1; t <= cycles; t++) begin
      bus.sel = 2'($urandom);
      step();
      q     = (t - 1) % SLOT;
      s     = (t - 1) / SLOT;
      e_row = 2'(r0 + s);
      e_out = (q < BLANK) ? 4'b0000 : (one << e_row);
      e_fs  = (q == BLANK) && (e_row == 2'd0);
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== {e_out, e_row, e_fs}) begin
        n_bad++;
        $display("FAIL auto_scan t%0d: out=%b row=%0d fs=%b required %b/%0d/%b",
                 t, bus.out, bus.row, bus.frame_start, e_out, e_row, e_fs);
      end
    end
    m_row = e_row;
    if (drop) begin
      bus.ena = 1'b0;
      step();
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== {4'b0000, m_row, 1'b0}) begin
        n_bad++;
        $display("FAIL auto_drop: out=%b row=%0d fs=%b required 0000/%0d/0", bus.out, bus.row, bus.frame_start, m_row);
      end
    end
  endtask

  // From IDLE, or while driving a row other than v in direct mode.
  task automatic test_direct_select(input logic [1:0] v, input int hold);
    logic [3:0] one;
    one      = 4'b0001;
    bus.mode = 1'b1;
    bus.sel  = v;
    bus.ena  = 1'b1;
    for (int t = 0; t < BLANK; t++) begin
      step();
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== {4'b0000, m_row, 1'b0}) begin
        n_bad++;
        $display("FAIL direct_blank v%0d t%0d: out=%b row=%0d fs=%b required 0000/%0d/0",
                 v, t, bus.out, bus.row, bus.frame_start, m_row);
      end
    end
    step();
    n_cmp++;
    if ({bus.out, bus.row, bus.frame_start} !== {one << v, v, (v == 2'd0)}) begin
      n_bad++;
      $display("FAIL direct_first v%0d: out=%b row=%0d fs=%b required %b/%0d/%b",
               v, bus.out, bus.row, bus.frame_start, one << v, v, (v == 2'd0));
    end
    for (int h = 1; h < hold; h++) begin
      step();
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== {one << v, v, 1'b0}) begin
        n_bad++;
        $display("FAIL direct_hold v%0d h%0d: out=%b row=%0d fs=%b required %b/%0d/0",
                 v, h, bus.out, bus.row, bus.frame_start, one << v, v);
      end
    end
    m_row = v;
  endtask

  task automatic test_drop(input int idle_cycles);
    bus.ena = 1'b0;
    for (int i = 0; i <= idle_cycles; i++) begin
      bus.mode = 1'($urandom);
      bus.sel  = 2'($urandom);
      step();
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== {4'b0000, m_row, 1'b0}) begin
        n_bad++;
        $display("FAIL drop_idle i%0d: out=%b row=%0d fs=%b required 0000/%0d/0",
                 i, bus.out, bus.row, bus.frame_start, m_row);
      end
    end
  endtask

  // Flipping mode during the blank keeps its full length; the final mode picks the row.
  task automatic test_mode_in_blank(input bit to_direct);
    logic [1:0] v, e_row;
    logic [3:0] one;
    one      = 4'b0001;
    v        = 2'($urandom);
    bus.mode = to_direct ? 1'b0 : 1'b1;
    bus.sel  = 2'($urandom);
    bus.ena  = 1'b1;
    step();
    bus.mode = to_direct;
    bus.sel  = v;
    for (int t = 1; t < BLANK; t++) begin
      step();
      n_cmp++;
      if ({bus.out, bus.row} !== {4'b0000, m_row}) begin
        n_bad++;
        $display("FAIL mode_blank t%0d: out=%b row=%0d required 0000/%0d", t, bus.out, bus.row, m_row);
      end
    end
    step();
    e_row = to_direct ? v : m_row;
    n_cmp++;
    if ({bus.out, bus.row, bus.frame_start} !== {one << e_row, e_row, (e_row == 2'd0)}) begin
      n_bad++;
      $display("FAIL mode_blank_drive dir%0d: out=%b row=%0d fs=%b required %b/%0d/%b",
               to_direct, bus.out, bus.row, bus.frame_start, one << e_row, e_row, (e_row == 2'd0));
    end
    m_row = e_row;
    test_drop(0);
  endtask

  task automatic test_reset_mid_drive();
    test_direct_select(2'd1, 3);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({bus.out, bus.row, bus.frame_start} !== 7'b0000_00_0) begin
        n_bad++;
        $display("FAIL reset_mid_drive c%0d: out=%b row=%0d fs=%b required 0000/0/0",
                 i, bus.out, bus.row, bus.frame_start);
      end
    end
    rst   = 1'b0;
    m_row = 2'd0;
    test_auto_scan(SLOT + 1, 1'b1);
  endtask

  task automatic test_random(input int episodes);
    int         n_sel;
    logic [1:0] v;
    for (int e = 0; e < episodes; e++) begin
      if ($urandom_range(0, 1) == 0) begin
        test_auto_scan($urandom_range(1, 40), 1'b1);
      end else begin
        n_sel = $urandom_range(1, 3);
        for (int k = 0; k < n_sel; k++) begin
          v = (k == 0) ? 2'($urandom) : 2'(m_row + 2'($urandom_range(1, 3)));
          test_direct_select(v, $urandom_range(1, 6));
        end
        test_drop(0);
      end
      test_drop($urandom_range(0, 2));
    end
  endtask

  initial begin
    bus.ena  = 1'b0;
    bus.mode = 1'b0;
    bus.sel  = 2'd0;
    test_reset();
    test_auto_scan(4 * SLOT + DWELL + BLANK, 1'b1);
    test_auto_scan(BLANK + DWELL + 1 + BLANK, 1'b1);
    test_auto_scan(BLANK + 1, 1'b1);
    test_drop(1);
    test_direct_select(2'd2, 20);
    test_direct_select(2'd1, 4);
    test_drop(0);
    test_mode_in_blank(1'b1);
    test_mode_in_blank(1'b0);
    test_reset_mid_drive();
    test_random(25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/row_scan_decoder.md
ROW_SCAN_DECODER -- requirements
Module: row_scan_decoder

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N; N SHALL be 1..6.
REQ-002 Parameter DWELL_CYCLES, default 1000: cycles each row is driven in scan mode; SHALL be >= 1.
REQ-003 Parameter BLANK_CYCLES, default 4: all-zero cycles inserted before each row is driven; SHALL be >= 1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ena  input  1  1 = run; 0 = outputs dark.
REQ-007 mode  input  1  0 = auto scan; 1 = direct select.
REQ-008 sel  input  N  row index used in direct mode.
REQ-009 out  output  2**N  registered one-hot row drive; all-zero when dark.
REQ-010 row  output  N  registered index of the current or pending row.
REQ-011 frame_start  output  1  registered one-cycle pulse.

Function
REQ-012 States: IDLE, BLANK, DRIVE; out SHALL be all-zero in IDLE and BLANK, and exactly 1<<row in DRIVE.
REQ-013 IDLE: ena=1 -> BLANK with cycle counter cleared; else stay.
REQ-014 BLANK SHALL last exactly BLANK_CYCLES cycles, then -> DRIVE; in mode=1, row SHALL load sel on that transition.
REQ-015 DRIVE, mode=0: after exactly DWELL_CYCLES cycles, row SHALL increment with wrap (2**N-1 -> 0) and state -> BLANK.
REQ-016 DRIVE, mode=1: stay in DRIVE while sel==row (dwell counter ignored); sel!=row -> BLANK next cycle; row SHALL load the sel value present on the BLANK->DRIVE edge.
REQ-017 Latency: ena sampled high at edge k from IDLE -> out first nonzero after edge k+BLANK_CYCLES.
REQ-018 frame_start SHALL be 1 for exactly the first cycle of DRIVE when row==0, in either mode; 0 otherwise.
REQ-019 ena=0 in any state -> IDLE next edge; out=0 and frame_start=0 from that edge; row retained; counter cleared.
REQ-020 mode change mid-DRIVE SHALL take effect next cycle per REQ-015/016; mode change in BLANK SHALL NOT shorten the blank.
REQ-021 ena and a dwell expiry in the same cycle: ena=0 wins; row SHALL NOT increment.
REQ-022 Counter width SHALL be $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); counter SHALL never wrap.
REQ-023 out SHALL never have more than one bit set in any cycle, including state transitions.

Reset
REQ-024 rst=1 at an edge: state=IDLE, out=0, row=0, frame_start=0, counter=0, regardless of ena/mode.
REQ-025 rst SHALL dominate ena; release with ena=1 -> BLANK on the first edge after release.

Structure
REQ-026 Shared package row_scan_pkg SHALL hold the state enum (IDLE, BLANK, DRIVE) and the counter-width function.
REQ-027 One combinational sub-module decoder_n_to_2n (N-bit index + enable -> 2**N one-hot) SHALL produce the next-out value; the top SHALL register it.

Verification (N=2, DWELL_CYCLES=3, BLANK_CYCLES=2)
REQ-028 rst 2 cycles, ena=0 -> out=0000, row=00, frame_start=0 for 10 cycles.
REQ-029 ena=1, mode=0 -> out 0000,0000, then 0001 x3, 0000 x2, 0010 x3, ..., 1000 x3, wrap to 0001; frame_start=1 only on each first 0001 cycle.
REQ-030 mode=1, sel=10 -> after 2 blank cycles out=0100 held 20 cycles; sel->01 -> 0000 x2 then 0010.
REQ-031 ena dropped mid-DRIVE on row=01 -> out=0000 next edge, row stays 01; ena=1 again -> 2 blank cycles then 0010.
REQ-032 rst asserted mid-DRIVE with ena=1 -> next edge out=0000, row=00; release -> 2 blank cycles then 0001 with frame_start=1.
REQ-033 Every test: assertion that out is zero or one-hot and equals 1<<row whenever nonzero.
